// File: rtl/rsa_modexp_engine.sv
// Modular exponentiation core, result = base^exponent mod modulus, built from a bit-serial interleaved modmul.
// Latency WIDTH*(1+popcount+msb)+1 cycles, or WIDTH*(1+2*EXP_WIDTH)+1 with RSA_CONST_TIME_EN defined; modulus==0 answers in 1.
// Backpressure: one command in flight, start_ready only in IDLE, result held in DONE until result_ready.
module rsa_modexp_engine #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 error,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        MUL    = 3'd2,
        SQR    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]     base_q;
    logic [WIDTH-1:0]     mod_q;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     acc;
    logic [EXP_WIDTH-1:0] e_reg;
    logic [EXP_WIDTH-1:0] e_shift;
    logic [WIDTH-1:0]     p;
    logic [CW-1:0]        cnt;
    logic                 error_q;
    logic                 mm_active;
    logic                 mm_last;

`ifdef RSA_CONST_TIME_EN
    localparam int BCW = $clog2(EXP_WIDTH + 1);
    logic [BCW-1:0] bit_cnt;
`endif

    // Modmul datapath: operands come straight from the state, since b_reg/acc are stable during a modmul.
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   p_dbl;
    logic [WIDTH-1:0] p_red;
    logic [WIDTH:0]   p_add;
    logic [WIDTH-1:0] mm_res;

    always_comb begin
        mm_a = base_q;
        mm_b = WIDTH'(1);
        case (state)
            MUL: begin
                mm_a = b_reg;
                mm_b = acc;
            end
            SQR: begin
                mm_a = b_reg;
                mm_b = b_reg;
            end
            default: ;
        endcase
        m_ext  = {1'b0, mod_q};
        p_dbl  = {p, 1'b0};
        p_red  = (p_dbl >= m_ext) ? WIDTH'(p_dbl - m_ext) : p_dbl[WIDTH-1:0];
        p_add  = mm_a[cnt] ? ({1'b0, p_red} + {1'b0, mm_b}) : {1'b0, p_red};
        mm_res = (p_add >= m_ext) ? WIDTH'(p_add - m_ext) : p_add[WIDTH-1:0];
    end

    assign mm_active = (state == REDUCE) || (state == MUL) || (state == SQR);
    assign mm_last   = mm_active && (cnt == '0);
    assign e_shift   = e_reg >> 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    state_next = (modulus == '0) ? DONE : REDUCE;
                end
            end
            REDUCE: begin
                if (mm_last) begin
`ifdef RSA_CONST_TIME_EN
                    state_next = MUL;
`else
                    if (e_reg == '0) begin
                        state_next = DONE;
                    end else if (e_reg[0]) begin
                        state_next = MUL;
                    end else begin
                        state_next = SQR;
                    end
`endif
                end
            end
            MUL: begin
                if (mm_last) begin
`ifdef RSA_CONST_TIME_EN
                    state_next = SQR;
`else
                    // The square after the top exponent bit would never be used.
                    state_next = (e_shift == '0) ? DONE : SQR;
`endif
                end
            end
            SQR: begin
                if (mm_last) begin
`ifdef RSA_CONST_TIME_EN
                    state_next = (bit_cnt == BCW'(EXP_WIDTH - 1)) ? DONE : MUL;
`else
                    state_next = e_shift[0] ? MUL : SQR;
`endif
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q  <= '0;
            mod_q   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            e_reg   <= '0;
            p       <= '0;
            cnt     <= '0;
            error_q <= 1'b0;
`ifdef RSA_CONST_TIME_EN
            bit_cnt <= '0;
`endif
        end else if (state == IDLE) begin
            if (start_valid) begin
                base_q  <= base;
                mod_q   <= modulus;
                e_reg   <= exponent;
                acc     <= '0;
                p       <= '0;
                cnt     <= CW'(WIDTH - 1);
                error_q <= (modulus == '0);
`ifdef RSA_CONST_TIME_EN
                bit_cnt <= '0;
`endif
            end
        end else if (mm_active) begin
            if (mm_last) begin
                // Next modmul starts on the following cycle with a cleared partial product.
                p   <= '0;
                cnt <= CW'(WIDTH - 1);
                case (state)
                    REDUCE: begin
                        b_reg <= mm_res;
                        acc   <= (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    end
                    MUL: begin
                        if (e_reg[0]) begin
                            acc <= mm_res;
                        end
                    end
                    SQR: begin
                        b_reg <= mm_res;
                        e_reg <= e_shift;
`ifdef RSA_CONST_TIME_EN
                        bit_cnt <= bit_cnt + BCW'(1);
`endif
                    end
                    default: ;
                endcase
            end else begin
                p   <= mm_res;
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign start_ready  = (state == IDLE) && reset;
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign result       = (state == DONE) ? acc : '0;
    assign error        = error_q;

endmodule

// File: doc/rsa_modexp_engine.md
# rsa_modexp_engine

Parametrised modular-exponentiation engine computing result = base^exponent mod modulus. It is the single arithmetic core shared by the RSA encryptor (public exponent) and decryptor (private exponent), replacing their fixed-width 64-bit exponentiators. Operand width and exponent width are generic. The block uses valid/ready handshakes on command and result, and has an optional constant-time mode for decryption paths.

## Interface
Parameters:
- WIDTH, 64: width of base, modulus, result; must be ≥ 4.
- EXP_WIDTH, WIDTH: width of exponent.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; all state cleared while low.
- start_valid  input  1  command present.
- start_ready  output  1  engine can accept a command; high only in IDLE.
- base  input  WIDTH  message or ciphertext; any value, reduced internally.
- exponent  input  EXP_WIDTH  encryption or decryption key.
- modulus  input  WIDTH  n.
- result_valid  output  1  result and error are valid.
- result_ready  input  1  consumer accepts result.
- result  output  WIDTH  base^exponent mod modulus.
- error  output  1  modulus was zero; qualified by result_valid.
- busy  output  1  high in every state except IDLE.

## Operation
- Accept on a clk edge with start_valid && start_ready. Operands are captured into internal registers and can change afterwards.
- States: IDLE, REDUCE, MUL, SQR, DONE.
- IDLE to DONE on accept if modulus == 0: result = 0, error = 1.
- Otherwise IDLE to REDUCE, with error = 0.
- Modular multiply (modmul a·b mod M, requires b < M) is bit-serial interleaved, one bit per cycle from MSB of a, exactly WIDTH cycles:
  - P ← 2P; if P ≥ M, P ← P−M.
  - Then if a[i], P ← P+b; if P ≥ M, P ← P−M.
  - Internal datapath is WIDTH+1 bits; there is no other reduction.
- REDUCE: b_reg ← modmul(base, 1), i.e. base mod M. On exit, acc ← (M == 1) ? 0 : 1 and the exponent shift register e ← exponent.
- Exponent is scanned LSB-first (right-to-left binary method).
- Per bit:
  - MUL: acc ← modmul(b_reg, acc) if e[0] == 1.
  - SQR: b_reg ← modmul(b_reg, b_reg).
  - Then e ← e >> 1.
- Default (no macro):
  - A bit with e[0] == 0 skips MUL.
  - SQR is skipped when the shifted e becomes 0.
  - DONE is entered when e becomes 0. exponent == 0 goes REDUCE to DONE with result = 1 mod M.
- DONE: result = acc and result_valid = 1, held stable until result_ready. The handshake edge returns the block to IDLE. result_valid and result_ready high together in DONE finish in that one cycle.
- start_valid in any non-IDLE state is ignored; there is no queueing.
- M == 1 gives result 0 with no special handling beyond the acc init.

## Timing
- Reset values: start_ready = 0 while reset is low and 1 in the first cycle after release. result_valid = 0, result = 0, error = 0, busy = 0.
- Reset low mid-operation aborts immediately to IDLE. The partial result is discarded and never presented.
- Latency is measured from the accept edge to the first cycle with result_valid high:
  - Default: WIDTH·(1 + popcount(exponent) + msb(exponent)) + 1, where msb = index of the highest set bit (0 when exponent == 0).
  - modulus == 0: 1 cycle.
- Every modmul occupies exactly WIDTH cycles with no gap between modmuls.
- A new command can be accepted one cycle after the result handshake, which is the first IDLE cycle.

## Configuration
- RSA_CONST_TIME_EN defined:
  - MUL executes for every bit. The product is written to acc only when e[0] == 1, otherwise it is discarded.
  - SQR executes for every bit including the last.
  - All EXP_WIDTH bits are scanned regardless of value.
  - Latency is always WIDTH·(1 + 2·EXP_WIDTH) + 1; the modulus == 0 path stays 1 cycle.
  - Result values are identical to the default.
- Not defined: the data-dependent early-skip schedule in Operation.

## Test plan
- WIDTH=16, base=4, exponent=13, modulus=497: result=445, error=0. result_valid rises 113 cycles after accept (default) or 529 cycles (RSA_CONST_TIME_EN, EXP_WIDTH=16).
- RSA round trip, WIDTH=16, n=3233:
  - 65^17 gives 2790.
  - 2790^2753 gives 65.
  - The second command is issued the cycle after the first handshake.
- Edges: modulus=0 gives result=0 and error=1 after 1 cycle. modulus=1 gives 0. exponent=0 with base=1234, modulus=3233 gives 1. base=5000, modulus=3233 (base ≥ M), exponent=1 gives 1767.
- Backpressure: hold result_ready=0 for 50 cycles in DONE. Required: result stable, start_ready=0, and start_valid pulses ignored.
- Reset: assert reset low mid-SQR. Outputs return to reset values asynchronously. The next command after release produces the correct result.
- WIDTH=64 default: 0x0123456789ABCDEF^65537 mod 0xC7970CEEDCC3B0754490201A7AA613CD matches the reference model on 64-bit-truncated operands. Also run 200 random triples against the software model.
